// File: rtl/morse_encoder_param.sv
// Parametrised Morse letter encoder: A-Z onto a single serial line with
// configurable dot/dash/gap lengths and a start/busy/done/err handshake.
module morse_encoder_param #(
    parameter int unsigned TICK_DIV         = 25000000,
    parameter int unsigned DASH_UNITS       = 3,
    parameter int unsigned GAP_UNITS        = 1,
    parameter int unsigned LETTER_GAP_UNITS = 3
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic [4:0] letter,
    input  logic       abort,
    output logic       morse,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] sym_left
);

    localparam int unsigned TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAXU = (DASH_UNITS > GAP_UNITS)
                                 ? ((DASH_UNITS > LETTER_GAP_UNITS) ? DASH_UNITS : LETTER_GAP_UNITS)
                                 : ((GAP_UNITS > LETTER_GAP_UNITS) ? GAP_UNITS : LETTER_GAP_UNITS);
    localparam int unsigned UW   = (MAXU > 1) ? $clog2(MAXU) : 1;

    typedef enum logic [1:0] {IDLE, MARK, GAP, TAIL} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [UW-1:0] unit_q, unit_d;
    logic [3:0]    pat_q, pat_d;
    logic [2:0]    sym_d;
    logic          done_d, err_d;
    logic [UW-1:0] unit_last;
    logic          tick_wrap, phase_end;
    logic [6:0]    lut_val;

    // {length, left-aligned pattern}; 1 = dash, MSB sent first
    function automatic logic [6:0] lut(input logic [4:0] l);
        case (l)
            5'd0:    lut = {3'd2, 4'b0100};
            5'd1:    lut = {3'd4, 4'b1000};
            5'd2:    lut = {3'd4, 4'b1010};
            5'd3:    lut = {3'd3, 4'b1000};
            5'd4:    lut = {3'd1, 4'b0000};
            5'd5:    lut = {3'd4, 4'b0010};
            5'd6:    lut = {3'd3, 4'b1100};
            5'd7:    lut = {3'd4, 4'b0000};
            5'd8:    lut = {3'd2, 4'b0000};
            5'd9:    lut = {3'd4, 4'b0111};
            5'd10:   lut = {3'd3, 4'b1010};
            5'd11:   lut = {3'd4, 4'b0100};
            5'd12:   lut = {3'd2, 4'b1100};
            5'd13:   lut = {3'd2, 4'b1000};
            5'd14:   lut = {3'd3, 4'b1110};
            5'd15:   lut = {3'd4, 4'b0110};
            5'd16:   lut = {3'd4, 4'b1101};
            5'd17:   lut = {3'd3, 4'b0100};
            5'd18:   lut = {3'd3, 4'b0000};
            5'd19:   lut = {3'd1, 4'b1000};
            5'd20:   lut = {3'd3, 4'b0010};
            5'd21:   lut = {3'd4, 4'b0001};
            5'd22:   lut = {3'd3, 4'b0110};
            5'd23:   lut = {3'd4, 4'b1001};
            5'd24:   lut = {3'd4, 4'b1011};
            5'd25:   lut = {3'd4, 4'b1100};
            default: lut = 7'd0;
        endcase
    endfunction

    assign lut_val   = lut(letter);
    assign tick_wrap = (tick_q == TW'(TICK_DIV - 1));
    assign phase_end = tick_wrap && (unit_q == unit_last);

    // Last unit index of the current phase
    always_comb begin
        unit_last = '0;
        case (state_q)
            MARK:    unit_last = pat_q[3] ? UW'(DASH_UNITS - 1) : '0;
            GAP:     unit_last = UW'(GAP_UNITS - 1);
            TAIL:    unit_last = UW'(LETTER_GAP_UNITS - 1);
            default: unit_last = '0;
        endcase
    end

    // Next state, latched letter and output values
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sym_d   = sym_left;
        done_d  = 1'b0;
        err_d   = 1'b0;
        tick_d  = '0;
        unit_d  = '0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (letter <= 5'd25) begin
                        pat_d   = lut_val[3:0];
                        sym_d   = lut_val[6:4];
                        state_d = MARK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MARK: begin
                if (abort) begin
                    state_d = IDLE;
                    sym_d   = 3'd0;
                end else if (phase_end) begin
                    pat_d   = {pat_q[2:0], 1'b0};
                    sym_d   = sym_left - 3'd1;
                    state_d = (sym_left == 3'd1) ? TAIL : GAP;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    sym_d   = 3'd0;
                end else if (phase_end) begin
                    state_d = MARK;
                end
            end
            TAIL: begin
                if (abort) begin
                    state_d = IDLE;
                    sym_d   = 3'd0;
                end else if (phase_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Counters restart on every state change and rest at zero in IDLE
        if (state_d != state_q || state_d == IDLE) begin
            tick_d = '0;
            unit_d = '0;
        end else if (tick_wrap) begin
            tick_d = '0;
            unit_d = unit_q + UW'(1);
        end else begin
            tick_d = tick_q + TW'(1);
            unit_d = unit_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            unit_q   <= '0;
            pat_q    <= '0;
            sym_left <= 3'd0;
            morse    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            unit_q   <= unit_d;
            pat_q    <= pat_d;
            sym_left <= sym_d;
            morse    <= (state_d == MARK);
            busy     <= (state_d != IDLE);
            done     <= done_d;
            err      <= err_d;
        end
    end

endmodule

// File: doc/morse_encoder_param.md
Name: morse_encoder_param

Overview:
- Parametrised successor to the lab Morse-code letter flasher.
- Encodes any letter A–Z (ITU Morse, up to 4 symbols) onto a single serial output.
- Dot, dash, intra-letter gap and end-of-letter gap lengths are configurable in units; the unit time is set by a clock-tick divider.
- Adds a start/busy/done handshake, synchronous abort and invalid-code error reporting. Sits between switch/key input logic and an LED or a downstream serial sink.

Parameters:
- TICK_DIV, 25000000, CLOCK_50 cycles per Morse unit (0.5 s at 50 MHz); must be >= 1.
- DASH_UNITS, 3, units the output stays high for a dash; >= 1.
- GAP_UNITS, 1, low units between symbols of the same letter; >= 1.
- LETTER_GAP_UNITS, 3, low units after the last symbol before done; >= 1.

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request to encode `letter`; level-sampled each clock.
- letter  input  5  letter code: 0=A … 25=Z; 26–31 are invalid.
- abort  input  1  synchronous cancel of the letter in progress.
- morse  output  1  serial Morse output; 1 = mark (LED on).
- busy  output  1  high while a letter is being sent, including the end-of-letter gap.
- done  output  1  one-cycle pulse on normal completion.
- err  output  1  one-cycle pulse when start is given with an invalid letter.
- sym_left  output  3  symbols not yet started, plus the current one if in MARK; 0 when idle.

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE; morse, busy, done, err = 0; sym_left = 0; all counters 0.
- Outputs: all registered. morse=1 exactly when state==MARK. busy=1 in MARK, GAP and TAIL.
- Letter table: pattern is MSB-first, 1=dash, 0=dot, length 1–4, standard ITU code.
  - Examples: A=.-, B=-..., E=., O=---, Q=--.-, S=..., T=-, Z=--.. .
- Internal counters:
  - Tick counter, width $clog2(TICK_DIV), counts 0..TICK_DIV-1; on wrap it increments the unit counter.
  - Unit counter compares against the current phase length.
  - Both counters clear on every state change.
- IDLE:
  - done and err default 0.
  - If start=1 and abort=0:
    - letter <= 25: latch pattern and length, set sym_left=length, go to MARK. morse rises on the next cycle.
    - letter > 25: pulse err for one cycle, stay IDLE, busy stays 0.
- MARK:
  - Lasts exactly TICK_DIV cycles for a dot, or DASH_UNITS*TICK_DIV cycles for a dash.
  - At the end: shift the pattern left and decrement sym_left.
  - If sym_left was 1 → TAIL, else → GAP.
- GAP: GAP_UNITS*TICK_DIV cycles low, then → MARK for the next symbol.
- TAIL: LETTER_GAP_UNITS*TICK_DIV cycles low, then → IDLE. On that same edge, done=1 and busy=0 for one cycle.
- start while busy is ignored; letter changes while busy are ignored because pattern and length are latched.
- start in the cycle done=1 is accepted (state is IDLE), so back-to-back letters need no idle cycle.
- abort=1 in MARK, GAP or TAIL:
  - next cycle: IDLE, morse=0, busy=0, sym_left=0.
  - no done pulse.
- abort=1 in IDLE: overrides start; nothing is accepted and no err is pulsed.
- Reset mid-letter: immediate return to reset values; no done pulse.
- TICK_DIV=1 is legal: each unit is one cycle and no phase is ever shortened or merged.

Test Plan (TICK_DIV=4, DASH_UNITS=3, GAP_UNITS=1, LETTER_GAP_UNITS=3; cycle 0 = edge sampling start):
- E (letter=4), start for one cycle → morse=1 on cycles 1–4, morse=0 on cycles 5–16 with busy=1, done=1 and busy=0 on cycle 17, sym_left 1→0 at the end of cycle 4.
- A (letter=0) → morse high 1–4, low 5–8, high 9–20, low 21–32, done on cycle 33; exactly one done pulse.
- Q (letter=16) followed by start with letter=19 (T) held high during the done cycle → T's mark starts the cycle after done; Q's pattern measured as 12/4/12/4/4/4/12 high/low cycles before the tail.
- letter=27 with start → err=1 for one cycle, busy, morse and done stay 0. Then letter=18 (S) → three 4-cycle marks separated by 4-cycle gaps.
- B sending, abort asserted on cycle 6 → next cycle morse=0, busy=0, sym_left=0, no done. start asserted together with abort while idle → ignored.
- resetn pulled low asynchronously mid-dash of O → outputs 0 immediately without waiting for a clock edge. After release, start O → full 12/4/12/4/12 pattern, then a 12-cycle tail, then done.
